// File: rtl/center_pkg.sv
// rtl/center_pkg.sv - shared constants, FSM states and coordinate clamp for the centroid tracker
package center_pkg;

    localparam int COORD_W = 12;
    localparam int CNT_W   = 24;
    localparam int SUM_W   = 36;
    localparam int H_ACT   = 1280;
    localparam int V_ACT   = 720;
    localparam int MIN_PIX = 64;

    typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

    // Any quotient at or beyond the active extent pins to the last valid coordinate.
    function automatic logic [COORD_W-1:0] clamp_coord(input logic [SUM_W-1:0] q,
                                                       input int unsigned     lim);
        if (q >= SUM_W'(lim)) begin
            return COORD_W'(lim - 1);
        end
        return q[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/center_track_if.sv
// rtl/center_track_if.sv - pixel-side inputs and published-center outputs of the centroid tracker
interface center_track_if;

    logic [11:0] VtcHCnt;
    logic [11:0] VtcVCnt;
    logic        de;
    logic [7:0]  pix_y;
    logic [7:0]  threshold;
    logic        frame_end;
    logic [11:0] center_h;
    logic [11:0] center_v;
    logic        center_valid;
    logic        no_target;
    logic        busy;

    modport master (
        output VtcHCnt, VtcVCnt, de, pix_y, threshold, frame_end,
        input  center_h, center_v, center_valid, no_target, busy
    );

    modport slave (
        input  VtcHCnt, VtcVCnt, de, pix_y, threshold, frame_end,
        output center_h, center_v, center_valid, no_target, busy
    );

endinterface

// File: rtl/seq_div.sv
// rtl/seq_div.sv - unsigned restoring divider, one quotient bit per cycle, MSB first
module seq_div #(
    parameter int N_W = 36,
    parameter int D_W = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic [N_W-1:0] quotient,
    output logic           done
);

    localparam int C_W = $clog2(N_W + 1);

    logic [N_W-1:0] quo_q;
    logic [D_W-1:0] rem_q;
    logic [D_W-1:0] dsr_q;
    logic [C_W-1:0] cnt_q;
    logic [D_W:0]   shifted;
    logic           ge;

    // The dividend register doubles as the quotient: its MSB feeds the
    // partial remainder while the new quotient bit enters at the LSB.
    assign shifted  = {rem_q, quo_q[N_W-1]};
    assign ge       = (shifted >= {1'b0, dsr_q});
    assign quotient = quo_q;
    assign done     = (cnt_q == C_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
            cnt_q <= C_W'(N_W);
        end else if (cnt_q != '0) begin
            quo_q <= {quo_q[N_W-2:0], ge};
            rem_q <= D_W'(ge ? (shifted - {1'b0, dsr_q}) : shifted);
            cnt_q <= cnt_q - C_W'(1);
        end
    end

endmodule

// File: rtl/center_track.sv
// rtl/center_track.sv - per-frame luminance centroid tracker publishing frame-stable center_h/center_v
module center_track
    import center_pkg::*;
(
    input  logic          PCLK,
    input  logic          rst_n,
    center_track_if.slave bus
);

    logic [SUM_W-1:0]   sum_x_q, sum_y_q, snap_x_q, snap_y_q;
    logic [CNT_W-1:0]   cnt_q, snap_cnt_q;
    logic [SUM_W-1:0]   sum_x_nxt, sum_y_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [SUM_W:0]     x_add, y_add;
    logic [CNT_W:0]     c_add;
    logic               qual;
    state_t             state_q;
    logic [COORD_W-1:0] center_h_q, center_v_q;
    logic               valid_q, no_target_q, busy_q;
    logic               snap_small, div_start, div_done_x, div_done_y;
    logic [SUM_W-1:0]   quo_x, quo_y;

    assign qual = bus.de && (bus.pix_y >= bus.threshold);

    // Saturating accumulate: the carry-out of each widened add selects all-ones.
    always_comb begin
        x_add     = {1'b0, sum_x_q} + (SUM_W+1)'(bus.VtcHCnt);
        y_add     = {1'b0, sum_y_q} + (SUM_W+1)'(bus.VtcVCnt);
        c_add     = {1'b0, cnt_q} + (CNT_W+1)'(1);
        sum_x_nxt = sum_x_q;
        sum_y_nxt = sum_y_q;
        cnt_nxt   = cnt_q;
        if (qual) begin
            sum_x_nxt = x_add[SUM_W] ? '1 : x_add[SUM_W-1:0];
            sum_y_nxt = y_add[SUM_W] ? '1 : y_add[SUM_W-1:0];
            cnt_nxt   = c_add[CNT_W] ? '1 : c_add[CNT_W-1:0];
        end
    end

    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
            cnt_q   <= '0;
        end else if (bus.frame_end) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
            cnt_q   <= '0;
        end else begin
            sum_x_q <= sum_x_nxt;
            sum_y_q <= sum_y_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign snap_small = (snap_cnt_q < CNT_W'(MIN_PIX));
    assign div_start  = (state_q == CHECK) && !snap_small;

    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            snap_x_q    <= '0;
            snap_y_q    <= '0;
            snap_cnt_q  <= '0;
            center_h_q  <= COORD_W'(H_ACT / 2);
            center_v_q  <= COORD_W'(V_ACT / 2);
            valid_q     <= 1'b0;
            no_target_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.frame_end) begin
                        snap_x_q   <= sum_x_nxt;
                        snap_y_q   <= sum_y_nxt;
                        snap_cnt_q <= cnt_nxt;
                        state_q    <= CHECK;
                    end
                end
                CHECK: begin
                    no_target_q <= snap_small;
                    if (snap_small) begin
                        state_q <= DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    if (div_done_x && div_done_y) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // A no-target frame still announces itself but keeps the last good center.
                    valid_q <= 1'b1;
                    if (!no_target_q) begin
                        center_h_q <= clamp_coord(quo_x, H_ACT);
                        center_v_q <= clamp_coord(quo_y, V_ACT);
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    seq_div #(.N_W(SUM_W), .D_W(CNT_W)) u_div_x (
        .clk      (PCLK),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (snap_x_q),
        .divisor  (snap_cnt_q),
        .quotient (quo_x),
        .done     (div_done_x)
    );

    seq_div #(.N_W(SUM_W), .D_W(CNT_W)) u_div_y (
        .clk      (PCLK),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (snap_y_q),
        .divisor  (snap_cnt_q),
        .quotient (quo_y),
        .done     (div_done_y)
    );

    assign bus.center_h     = center_h_q;
    assign bus.center_v     = center_v_q;
    assign bus.center_valid = valid_q;
    assign bus.no_target    = no_target_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_center_track.sv
// tb/tb_center_track.sv - directed table-driven bench for center_track
module tb_center_track;

    logic PCLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 PCLK = ~PCLK;

    center_track_if bus();

    center_track dut (
        .PCLK  (PCLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string name;
        int    ax, ay, aw, ah;
        int    bx, by, bw, bh;
        int    luma, thr;
        int    exp_edge, eh, ev;
        int    ent;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.de        = 1'b0;
        bus.pix_y     = 8'd0;
        bus.frame_end = 1'b0;
    endtask

    task automatic drive_px(input int h, input int v, input int y, input bit en);
        bus.VtcHCnt = 12'(h);
        bus.VtcVCnt = 12'(v);
        bus.pix_y   = 8'(y);
        bus.de      = en;
        tick();
    endtask

    task automatic send_block(input int x, input int y, input int w, input int h, input int luma);
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
                drive_px(x + i, y + j, luma, 1'b1);
        idle_inputs();
    endtask

    // Edge 0 is the edge that samples frame_end; the result edge is counted from there.
    task automatic close_frame(input string nm, input bit px_en, input int ph, input int pv,
                               input int exp_edge, input int eh, input int ev, input int ent);
        int got;
        int stable;
        logic [11:0] h0, v0;
        h0 = bus.center_h;
        v0 = bus.center_v;
        bus.frame_end = 1'b1;
        bus.de        = px_en;
        bus.VtcHCnt   = 12'(ph);
        bus.VtcVCnt   = 12'(pv);
        bus.pix_y     = px_en ? 8'd255 : 8'd0;
        tick();
        idle_inputs();
        got    = -1;
        stable = 1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (bus.center_valid) begin
                got = k;
                break;
            end
            if (bus.center_h != h0 || bus.center_v != v0) stable = 0;
        end
        check({nm, " valid_edge"}, got, exp_edge);
        check({nm, " center_h"}, int'(bus.center_h), eh);
        check({nm, " center_v"}, int'(bus.center_v), ev);
        check({nm, " no_target"}, int'(bus.no_target), ent);
        check({nm, " stable_before_valid"}, stable, 1);
        tick();
        check({nm, " valid_one_cycle"}, int'(bus.center_valid), 0);
    endtask

    initial begin
        int got;
        int extra;

        bus.VtcHCnt   = '0;
        bus.VtcVCnt   = '0;
        bus.threshold = 8'd128;
        idle_inputs();

        vecs[0] = '{"empty",      0,    0,    0,  0,  0,   0,   0, 0, 200, 128,  2,  640, 360, 1};
        vecs[1] = '{"block10",    300,  100,  10, 10, 0,   0,   0, 0, 200, 128, 38,  304, 104, 0};
        vecs[2] = '{"two_blocks", 97,   47,   8,  8,  496, 246, 8, 8, 200, 128, 38,  300, 150, 0};
        vecs[3] = '{"few_pix",    0,    0,    10, 1,  0,   0,   0, 0, 200, 128,  2,  300, 150, 1};
        vecs[4] = '{"clamp",      4000, 1000, 8,  8,  0,   0,   0, 0, 200, 128, 38, 1279, 719, 0};
        vecs[5] = '{"thr_equal",  20,   30,   10, 10, 0,   0,   0, 0, 200, 200, 38,   24,  34, 0};

        repeat (3) tick();
        check("reset center_h", int'(bus.center_h), 640);
        check("reset center_v", int'(bus.center_v), 360);
        check("reset valid", int'(bus.center_valid), 0);
        check("reset no_target", int'(bus.no_target), 0);
        check("reset busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int n = 0; n < 6; n++) begin
            bus.threshold = 8'(vecs[n].thr);
            if (vecs[n].aw > 0) send_block(vecs[n].ax, vecs[n].ay, vecs[n].aw, vecs[n].ah, vecs[n].luma);
            if (vecs[n].bw > 0) send_block(vecs[n].bx, vecs[n].by, vecs[n].bw, vecs[n].bh, vecs[n].luma);
            repeat (3) drive_px(1000, 700, vecs[n].thr - 1, 1'b1);
            repeat (3) drive_px(5, 5, 255, 1'b0);
            idle_inputs();
            close_frame(vecs[n].name, 1'b0, 0, 0, vecs[n].exp_edge, vecs[n].eh, vecs[n].ev, vecs[n].ent);
        end

        // Pixel coinciding with frame_end belongs to the closing frame (63 + 1 reaches MIN_PIX).
        bus.threshold = 8'd128;
        send_block(1264, 704, 9, 7, 200);
        close_frame("edge_px", 1'b1, 1279, 719, 38, 1268, 707, 0);
        send_block(600, 300, 9, 9, 200);
        close_frame("after_edge_px", 1'b0, 0, 0, 38, 604, 304, 0);

        // Second frame_end during DIV is dropped and its pixels discarded.
        send_block(300, 100, 10, 10, 200);
        bus.frame_end = 1'b1;
        tick();
        idle_inputs();
        for (int k = 1; k <= 9; k++) drive_px(1000, 600, 255, 1'b1);
        bus.de        = 1'b0;
        bus.frame_end = 1'b1;
        tick();
        idle_inputs();
        check("drop busy_at_edge10", int'(bus.busy), 1);
        got = -1;
        for (int k = 11; k <= 60; k++) begin
            tick();
            if (bus.center_valid) begin
                got = k;
                break;
            end
        end
        check("drop valid_edge", got, 38);
        check("drop center_h", int'(bus.center_h), 304);
        check("drop center_v", int'(bus.center_v), 104);
        check("drop busy_after", int'(bus.busy), 0);
        extra = 0;
        repeat (50) begin
            tick();
            if (bus.center_valid) extra++;
        end
        check("drop no_extra_valid", extra, 0);
        send_block(200, 400, 8, 8, 200);
        close_frame("after_drop", 1'b0, 0, 0, 38, 203, 403, 0);

        // Asynchronous reset in the middle of a division.
        send_block(300, 100, 10, 10, 200);
        bus.frame_end = 1'b1;
        tick();
        idle_inputs();
        repeat (20) tick();
        check("abort busy_before", int'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", int'(bus.busy), 0);
        check("abort center_h", int'(bus.center_h), 640);
        check("abort center_v", int'(bus.center_v), 360);
        check("abort no_target", int'(bus.no_target), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        extra = 0;
        repeat (50) begin
            tick();
            if (bus.center_valid) extra++;
        end
        check("abort no_valid", extra, 0);
        send_block(300, 100, 10, 10, 200);
        close_frame("after_abort", 1'b0, 0, 0, 38, 304, 104, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/center_track.md
Name: center_track

Overview:
- Per-frame luminance centroid tracker.
- Produces the center_h/center_v coordinates consumed by the center-weighted metering logic, i.e. the producer side of that interface.
- Accumulates the coordinates of every active pixel at or above a brightness threshold. At frame end it divides the sums by the pixel count in a sequential divider and publishes a registered, frame-stable center.
- Sits in the timing/ISP path alongside the VTC counters, in the PCLK domain.

Parameters:
- H_ACT, 1280, active width; reset/default center_h = H_ACT/2.
- V_ACT, 720, active height; reset/default center_v = V_ACT/2.
- CNT_W, 24, pixel-count accumulator width.
- SUM_W, 36, coordinate-sum accumulator width (12 + CNT_W).
- MIN_PIX, 64, minimum qualifying pixel count for a valid centroid.

Ports:
- PCLK  in  1  pixel clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- VtcHCnt  in  12  current horizontal pixel coordinate.
- VtcVCnt  in  12  current vertical line coordinate.
- de  in  1  active-video qualifier.
- pix_y  in  8  pixel luminance, aligned with the counters and de.
- threshold  in  8  brightness threshold; sampled every cycle.
- frame_end  in  1  single-cycle pulse after the last active pixel of a frame.
- center_h  out  12  published horizontal centroid.
- center_v  out  12  published vertical centroid.
- center_valid  out  1  one-cycle pulse when the centers update.
- no_target  out  1  high when the last completed frame had count < MIN_PIX.
- busy  out  1  high while the divider runs.

Behaviour:
- Reset (async, rst_n=0):
  - center_h=H_ACT/2, center_v=V_ACT/2, center_valid=0, no_target=0, busy=0.
  - Accumulators, snapshot registers and divider are all cleared; FSM goes to IDLE.
  - Asserting reset mid-division aborts the division; no center_valid is produced.
- Accumulate, every PCLK with de=1 and pix_y >= threshold:
  - sum_x += VtcHCnt, sum_y += VtcVCnt, cnt += 1.
  - All three saturate at all-ones and never wrap.
- Snapshot on frame_end=1 while FSM=IDLE:
  - sum_x, sum_y and cnt are copied to snapshot registers and the accumulators clear to 0 on the same edge.
  - A qualifying pixel in the same cycle as frame_end is included in the snapshot; the new frame starts from 0.
- frame_end while busy:
  - Snapshot skipped, frame dropped, accumulators still clear.
  - The published center is unchanged.
- FSM:
  - IDLE -> (frame_end) CHECK.
  - CHECK:
    - if snap_cnt < MIN_PIX: no_target=1, center held, center_valid pulses; back to IDLE.
    - else no_target=0, start both dividers; -> DIV.
  - DIV: busy=1 for SUM_W cycles -> DONE.
  - DONE: quotients saturated to 12 bits and clamped to H_ACT-1 / V_ACT-1, written to center_h/center_v; center_valid=1 for one cycle; -> IDLE.
- Latency:
  - Count the edge that samples frame_end as edge 0. CHECK occupies edge 1, DIV occupies edges 2..SUM_W+1, and center_valid/center update at edge SUM_W+2 (38 with defaults).
  - In the no_target case, center_valid is at edge 2.
- Division:
  - Unsigned restoring division, one quotient bit per cycle, MSB first.
  - Truncating (floor) result; the remainder is discarded.
  - Divisor is never 0, because MIN_PIX >= 1 is required.
- Output stability: center_h/center_v change only on a center_valid edge and are constant between updates, so the downstream weight computation sees frame-stable values.

Decomposition:
- Shared package center_pkg holds:
  - constants COORD_W=12, CNT_W, SUM_W, H_ACT, V_ACT;
  - state enum {IDLE, CHECK, DIV, DONE}.
- Sub-module seq_div (parameters N_W=SUM_W, D_W=CNT_W):
  - ports start, dividend, divisor, quotient, done;
  - instantiated twice (x and y) and run in lockstep.

Test Plan:
1. Reset release, then frame_end with no pixels -> center_valid at edge 2, center=(640,360), no_target=1.
2. threshold=128; a 10x10 block of pix_y=200 at H 300..309, V 100..109 (cnt=100, sum_x=30450, sum_y=10450); frame_end -> center_valid at edge 38, center_h=304, center_v=104, no_target=0.
3. Two blocks of 64 pixels each, centered at (100,50) and (500,250) -> center (300,150). A following frame with only 10 qualifying pixels -> no_target=1 and center remains (300,150).
4. Qualifying pixel at (1279,719) in the same cycle as frame_end -> included in the closing frame. The next frame's accumulators start at 0, checked via a single-block next frame giving an exact centroid.
5. Second frame_end at edge 10 of a DIV -> no restart; result from the first frame only; the dropped frame never produces center_valid.
6. rst_n pulsed low at edge 20 of DIV -> no center_valid; outputs return to (640,360), busy=0 asynchronously; a subsequent normal frame computes correctly.
